// File: rtl/mem_copy_dma.sv
// mem_copy_dma
// ----------------------------------------------------------------------------
// Memory-port initiator that copies a block of 32-bit words from a source to
// a destination byte address over a single-port RAM request interface with
// 1-cycle read latency. Each word takes two cycles: a read of the source
// pointer followed by a write of the returned data to the destination pointer.
//
// Parameters:
//   ADDR_WIDTH  byte-address width of the RAM port (pointers wrap modulo 2^W)
//   LEN_WIDTH   width of the word-count input
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     copy request, sampled only while idle
//   src_addr_i  source byte address (word-aligned)
//   dst_addr_i  destination byte address (word-aligned)
//   len_i       number of words to copy
//   busy_o      high from the first cycle after an accepted start through done
//   done_o      one-cycle completion pulse
//   err_o       sticky misalignment flag, cleared by the next accepted start
//   csum_o      running modulo-2^32 sum of written words (optional)
//   en_o/addr_o/we_o/be_o/wdata_o  RAM request
//   rdata_i     RAM read data, valid the cycle after a read request
//
// Configuration:
//   MEM_COPY_DMA_CSUM_EN  when defined, builds the checksum register; when
//                         undefined, csum_o is tied to zero.
// ----------------------------------------------------------------------------
module mem_copy_dma #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           csum_o,
  output logic                  en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  output logic [31:0]           wdata_o,
  input  logic [31:0]           rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
  localparam logic [LEN_WIDTH-1:0]  ONE_WORD  = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  misaligned;

  assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

  // State, pointer, count and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and RAM request decode. Outputs come straight from the
  // current state so an asynchronous reset drops the request immediately.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    en_o    = 1'b0;
    we_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = src_addr_i;
          dst_d = dst_addr_i;
          cnt_d = len_i;
          err_d = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (len_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        busy_o  = 1'b1;
        en_o    = 1'b1;
        addr_o  = src_q;
        state_d = WRITE;
      end

      WRITE: begin
        busy_o  = 1'b1;
        en_o    = 1'b1;
        we_o    = 1'b1;
        addr_o  = dst_q;
        // Read data from the previous cycle is forwarded without a holding
        // register; this is what keeps throughput at one word per two cycles.
        wdata_o = rdata_i;
        src_d   = src_q + WORD_STEP;
        dst_d   = dst_q + WORD_STEP;
        cnt_d   = cnt_q - ONE_WORD;
        state_d = (cnt_q == ONE_WORD) ? DONE : READ;
      end

      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign be_o  = en_o ? 4'hF : 4'h0;
  assign err_o = err_q;

`ifdef MEM_COPY_DMA_CSUM_EN
  logic [31:0] csum_q, csum_d;

  // Checksum accumulates every word as it is written and clears on an
  // accepted start; it therefore holds its final value from DONE onward.
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start_i) begin
      csum_d = 32'h0;
    end else if (state_q == WRITE) begin
      csum_d = csum_q + rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= 32'h0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = 32'h0;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma
// ----------------------------------------------------------------------------
// Self-checking bench for mem_copy_dma. A behavioural RAM answers the DUT's
// requests; a word-level reference memory plus a cycle timeline computed from
// the copy parameters provides every expected value.
// ----------------------------------------------------------------------------
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  src_addr_i;
  logic [7:0]  dst_addr_i;
  logic [6:0]  len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] csum_o;
  logic        en_o;
  logic [7:0]  addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;

  logic [31:0] ram     [64];
  logic [31:0] exp_mem [64];

  int checks   = 0;
  int failures = 0;

  mem_copy_dma #(.ADDR_WIDTH(8), .LEN_WIDTH(7)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .csum_o     (csum_o),
    .en_o       (en_o),
    .addr_o     (addr_o),
    .we_o       (we_o),
    .be_o       (be_o),
    .wdata_o    (wdata_o),
    .rdata_i    (rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (en_o) begin
      if (we_o) ram[addr_o[7:2]] <= wdata_o;
      else      rdata_i <= ram[addr_o[7:2]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkMemory(input string tag);
    for (int i = 0; i < 64; i++) begin
      checkOutput($sformatf("%s_mem%0d", tag, i), ram[i], exp_mem[i]);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    ram[idx]     = val;
    exp_mem[idx] = val;
  endtask

  // Run one copy request. retrig: cycle in which start_i is pulsed again
  // (0 = none). rst_at: cycle in which rst_ni is pulled low (0 = none).
  task automatic applyStimulus(input string tag, input logic [7:0] src, input logic [7:0] dst,
                               input logic [6:0] len, input int retrig, input int rst_at);
    logic [31:0] scratch [64];
    logic [31:0] wval    [128];
    logic [31:0] sum;
    logic [31:0] exp_csum;
    logic [31:0] exp_wdata;
    logic [7:0]  exp_addr;
    bit          mis;
    bit          rd;
    int          words;
    int          done_c;
    int          last;
    int          k;
    int          s_idx;
    int          d_idx;

    mis    = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
    words  = mis ? 0 : int'(len);
    done_c = 2 * words + 1;
    last   = (rst_at > 0) ? rst_at : done_c;

    // Reference model: forward word-by-word copy on a scratch image; only
    // writes whose cycle completed before a reset are committed.
    scratch = exp_mem;
    sum     = 32'h0;
    for (int w = 0; w < words; w++) begin
      s_idx          = ((int'(src) + 4 * w) % 256) / 4;
      d_idx          = ((int'(dst) + 4 * w) % 256) / 4;
      wval[w]        = scratch[s_idx];
      scratch[d_idx] = wval[w];
      sum            = sum + wval[w];
      if (rst_at == 0 || (2 * w + 2) < rst_at) exp_mem[d_idx] = wval[w];
    end
`ifdef MEM_COPY_DMA_CSUM_EN
    exp_csum = sum;
`else
    exp_csum = 32'h0;
`endif

    @(negedge clk);
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = len;
    start_i    = 1'b1;

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
      if (c <= 2 * words) begin
        k         = (c - 1) / 2;
        rd        = (c % 2) == 1;
        exp_addr  = rd ? 8'((int'(src) + 4 * k) % 256) : 8'((int'(dst) + 4 * k) % 256);
        exp_wdata = rd ? 32'h0 : wval[k];
        checkOutput($sformatf("%s_c%0d_en", tag, c), en_o, 1'b1);
        checkOutput($sformatf("%s_c%0d_we", tag, c), we_o, !rd);
        checkOutput($sformatf("%s_c%0d_addr", tag, c), addr_o, exp_addr);
        checkOutput($sformatf("%s_c%0d_be", tag, c), be_o, 4'hF);
        checkOutput($sformatf("%s_c%0d_wdata", tag, c), wdata_o, exp_wdata);
      end else begin
        checkOutput($sformatf("%s_c%0d_en", tag, c), en_o, 1'b0);
        checkOutput($sformatf("%s_c%0d_be", tag, c), be_o, 4'h0);
        checkOutput($sformatf("%s_c%0d_wdata", tag, c), wdata_o, 32'h0);
      end
      checkOutput($sformatf("%s_c%0d_busy", tag, c), busy_o, 1'b1);
      checkOutput($sformatf("%s_c%0d_done", tag, c), done_o, c == done_c);
      checkOutput($sformatf("%s_c%0d_err", tag, c), err_o, mis);
      if (c == done_c) checkOutput($sformatf("%s_csum_done", tag), csum_o, exp_csum);

      if (c == retrig)     start_i = 1'b1;
      if (c == retrig + 1) start_i = 1'b0;

      if (c == rst_at) begin
        rst_ni = 1'b0;
        #1;
        checkOutput($sformatf("%s_rst_en", tag), en_o, 1'b0);
        checkOutput($sformatf("%s_rst_busy", tag), busy_o, 1'b0);
        checkOutput($sformatf("%s_rst_done", tag), done_o, 1'b0);
        @(negedge clk);
        checkOutput($sformatf("%s_rst_csum", tag), csum_o, 32'h0);
        checkOutput($sformatf("%s_rst_err", tag), err_o, 1'b0);
        rst_ni  = 1'b1;
        start_i = 1'b0;
      end
    end

    if (rst_at == 0) begin
      @(negedge clk);
      checkOutput($sformatf("%s_idle_busy", tag), busy_o, 1'b0);
      checkOutput($sformatf("%s_idle_done", tag), done_o, 1'b0);
      checkOutput($sformatf("%s_idle_en", tag), en_o, 1'b0);
      checkOutput($sformatf("%s_idle_err", tag), err_o, mis);
      checkOutput($sformatf("%s_idle_csum", tag), csum_o, exp_csum);
    end
    checkMemory(tag);
  endtask

  initial begin
    logic [7:0] r_src;
    logic [7:0] r_dst;
    logic [6:0] r_len;

    rst_ni     = 1'b0;
    start_i    = 1'b0;
    src_addr_i = 8'h0;
    dst_addr_i = 8'h0;
    len_i      = 7'h0;
    rdata_i    = 32'h0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);

    #1;
    checkOutput("reset_busy", busy_o, 1'b0);
    checkOutput("reset_done", done_o, 1'b0);
    checkOutput("reset_err", err_o, 1'b0);
    checkOutput("reset_csum", csum_o, 32'h0);
    checkOutput("reset_en", en_o, 1'b0);
    checkOutput("reset_we", we_o, 1'b0);
    checkOutput("reset_be", be_o, 4'h0);
    checkOutput("reset_addr", addr_o, 8'h0);
    checkOutput("reset_wdata", wdata_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    $display("[TB] basic block copy");
    preload(0, 32'h11111111);
    preload(1, 32'h22222222);
    preload(2, 32'h33333333);
    preload(3, 32'h44444444);
    applyStimulus("basic", 8'h00, 8'h40, 7'd4, 0, 0);
    checkOutput("basic_dst0", ram[16], 32'h11111111);
    checkOutput("basic_dst3", ram[19], 32'h44444444);

    $display("[TB] zero length and misaligned");
    applyStimulus("len0", 8'h00, 8'h40, 7'd0, 0, 0);
    applyStimulus("misal", 8'h02, 8'h40, 7'd3, 0, 0);

    $display("[TB] address wrap");
    applyStimulus("wrap", 8'hF8, 8'h10, 7'd3, 0, 0);

    $display("[TB] start ignored while busy");
    applyStimulus("retrig", 8'h20, 8'h80, 7'd4, 3, 0);

    $display("[TB] overlapping forward copy");
    preload(0, 32'hA5A5A5A5);
    applyStimulus("overlap", 8'h00, 8'h04, 7'd3, 0, 0);
    checkOutput("overlap_w3", ram[3], 32'hA5A5A5A5);

    $display("[TB] reset mid-copy");
    applyStimulus("abort", 8'h00, 8'hC0, 7'd4, 0, 5);
    applyStimulus("after_rst", 8'h30, 8'hA0, 7'd2, 0, 0);

    $display("[TB] random copies");
    for (int t = 0; t < 6; t++) begin
      r_src = 8'($urandom_range(0, 63) * 4);
      r_dst = 8'($urandom_range(0, 63) * 4);
      r_len = 7'($urandom_range(1, 10));
      applyStimulus($sformatf("rand%0d", t), r_src, r_dst, r_len, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
